bram_reader: RTL
================

BRAM_READER -- requirements
Module: bram_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32: BRAM/stream word width.
REQ-002 SHALL have parameter DEPTH, default 2048: words per BRAM (A and B); frame max = 2*DEPTH.
REQ-003 SHALL have port clk input 1: single clock, all logic on posedge.
REQ-004 SHALL have port rst input 1: synchronous, active-high reset.
REQ-005 SHALL have port sinc input 1: pulse-window signal, same as the capture controller's.
REQ-006 SHALL have port rdy input 2: capture status; 01 = BRAM A valid, 11 = A and B valid, 00 = none.
REQ-007 SHALL have port size_data input 32: total captured words in the frame.
REQ-008 SHALL have port rdy_w output 2: ownership back to the controller; nonzero blocks new capture.
REQ-009 SHALL have port bram_addr output log2(DEPTH): read word address.
REQ-010 SHALL have ports bram_en_a and bram_en_b, each output 1: read enables.
REQ-011 SHALL have ports bram_dout_a and bram_dout_b, each input DATA_W: read data, valid 1 clk after the enable.
REQ-012 SHALL have ports m_axis_tdata output DATA_W, m_axis_tvalid output 1, m_axis_tready input 1, m_axis_tlast output 1: AXI-Stream master.
REQ-013 SHALL have port frame_done output 1: 1-clk pulse when the last beat is accepted.

Function
REQ-014 SHALL implement states IDLE, READ, DRAIN, WAIT_CLR.
REQ-015 Start condition, evaluated in IDLE only:
- rdy==11, or
- rdy==01 with sinc==0 on 2 consecutive clks.
REQ-016 On start, SHALL latch N = size_data clamped to 1..2*DEPTH (0->1, >2*DEPTH -> 2*DEPTH).
REQ-017 On start, SHALL set rdy_w=01, and 11 if N>DEPTH; then go to READ.
REQ-018 READ SHALL issue one read per clk while space is available:
- words 0..min(N,DEPTH)-1 from A (bram_en_a, addr 0..).
- then words 0..N-DEPTH-1 from B (bram_en_b, addr restarts at 0).
- bram_en_a and bram_en_b SHALL never be high together.
REQ-019 Returned data SHALL enter a 2-entry output FIFO.
- Reads SHALL be issued only when FIFO occupancy + in-flight < 2, so no data is lost under backpressure.
- Sustained throughput SHALL be 1 word/clk when tready=1.
REQ-020 The stream SHALL follow AXI-Stream rules:
- tvalid SHALL NOT drop, and tdata/tlast SHALL NOT change, while tvalid=1 and tready=0.
- A beat transfers when tvalid&tready.
REQ-021 tlast SHALL be 1 only on beat N-1, the frame's final word.
REQ-022 After the last read is issued, SHALL go to DRAIN; when the last beat transfers, SHALL pulse frame_done and go to WAIT_CLR.
REQ-023 On entering WAIT_CLR, SHALL drive rdy_w=00.
REQ-024 WAIT_CLR SHALL return to IDLE only after sampling rdy==00, so a stale rdy never retriggers.
REQ-025 Word and address counters SHALL be 13 and log2(DEPTH) bits wide; counters SHALL NOT wrap within a frame.
REQ-026 Input changes on rdy, size_data or sinc during READ/DRAIN SHALL be ignored; N is fixed at start.

Reset
REQ-027 While rst=1, SHALL force on the next clk:
- state IDLE, FIFO empty, counters 0.
- rdy_w=00, bram_en_a=0, bram_en_b=0, bram_addr=0.
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, frame_done=0.
REQ-028 Reset mid-frame SHALL abort immediately with no further beats; in-flight read data SHALL be discarded.
REQ-029 After reset, the sinc qualifier history SHALL be cleared (2 fresh cycles required).

Verification
REQ-030 rdy=11, size_data=4096, tready=1 -> 4096 beats on consecutive clks:
- A addr 0..2047, then B addr 0..2047.
- tlast on beat 4095; frame_done 1 clk.
- rdy_w 11 -> 00.
REQ-031 rdy=01, sinc=0 for 2 clks, size_data=100 -> 100 beats from A only:
- bram_en_b never high; rdy_w=01; tlast on beat 99.
REQ-032 rdy=01, sinc=0 for exactly 1 clk, then rdy=11, size_data=2500 -> single start on rdy=11:
- 2048 beats from A + 452 from B.
REQ-033 size_data=3000, rdy=11, tready toggling 1010... and random stalls -> 3000 beats in order:
- data stable during stalls, no loss or duplication; tlast only on beat 2999.
REQ-034 rst=1 asserted at beat 1000 of a 4096 frame -> next clk:
- tvalid=0, rdy_w=00, enables 0.
- with rdy held at 11, a new frame starts only after 1 clk in IDLE and restarts at A addr 0.
REQ-035 After frame_done with rdy held at 11 for 50 clks -> no restart; rdy=00 then 11 -> a new frame starts.

Source files
------------

// File: rtl/bram_reader_if.sv
// bram_reader_if: BRAM read port plus AXI-Stream master bundle.
interface bram_reader_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0]     bram_addr;
    logic              bram_en_a;
    logic              bram_en_b;
    logic [DATA_W-1:0] bram_dout_a;
    logic [DATA_W-1:0] bram_dout_b;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    modport master (
        output bram_addr, bram_en_a, bram_en_b, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  bram_dout_a, bram_dout_b, m_axis_tready
    );
    modport slave (
        input  bram_addr, bram_en_a, bram_en_b, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output bram_dout_a, bram_dout_b, m_axis_tready
    );
endinterface

// File: rtl/bram_reader.sv
// bram_reader: streams a captured frame out of BRAM A then B over AXI-Stream,
// with a 2-entry skid FIFO so reads never outrun downstream backpressure.
module bram_reader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sinc,
    input  logic [1:0]    rdy,
    input  logic [31:0]   size_data,
    output logic [1:0]    rdy_w,
    output logic          frame_done,
    bram_reader_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [12:0] NMAX = 13'(2 * DEPTH);
    typedef enum logic [1:0] {IDLE, READ, DRAIN, WAIT_CLR} state_t;
    state_t            state_q, state_d;
    logic [12:0]       n_q, n_d, rd_cnt_q, rd_cnt_d, out_cnt_q, out_cnt_d, n_new;
    logic [AW-1:0]     addr_q, addr_d;
    logic [1:0]        rdy_w_q, rdy_w_d, cnt_q, cnt_d;
    logic              sinc_lo_q, sinc_lo_d, rd_vld_q, rd_vld_d, rd_b_q, rd_b_d;
    logic              wp_q, wp_d, rp_q, rp_d;
    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              start, issue, in_b, tvalid, pop, last;
    assign n_new  = size_data == 32'd0 ? 13'd1 : size_data > 32'(2 * DEPTH) ? NMAX : size_data[12:0];
    assign start  = rdy == 2'b11 || (rdy == 2'b01 && !sinc && sinc_lo_q);
    assign tvalid = cnt_q != 2'd0;
    assign pop    = tvalid && bus.m_axis_tready;
    assign last   = out_cnt_q == n_q - 13'd1;
    // A slot freed by this cycle's pop counts as space, keeping 1 word/clk.
    assign issue  = state_q == READ && 3'(cnt_q) + 3'(rd_vld_q) < 3'(pop) + 3'd2;
    assign in_b   = rd_cnt_q >= 13'(DEPTH);
    assign bus.bram_addr     = addr_q;
    assign bus.bram_en_a     = issue && !in_b;
    assign bus.bram_en_b     = issue && in_b;
    assign bus.m_axis_tdata  = mem_q[rp_q];
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tlast  = tvalid && last;
    assign frame_done        = pop && last;
    assign rdy_w             = rdy_w_q;
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        rdy_w_d   = rdy_w_q;
        sinc_lo_d = state_q == IDLE && !sinc;
        rd_vld_d  = issue;
        rd_b_d    = in_b;
        rd_cnt_d  = issue ? rd_cnt_q + 13'd1 : rd_cnt_q;
        addr_d    = issue ? (rd_cnt_q == 13'(DEPTH - 1) ? '0 : addr_q + 1'b1) : addr_q;
        out_cnt_d = out_cnt_q + 13'(pop);
        wp_d      = wp_q ^ rd_vld_q;
        rp_d      = rp_q ^ pop;
        cnt_d     = cnt_q + 2'(rd_vld_q) - 2'(pop);
        mem_d     = mem_q;
        if (rd_vld_q) mem_d[wp_q] = rd_b_q ? bus.bram_dout_b : bus.bram_dout_a;
        case (state_q)
            IDLE: if (start) begin
                state_d   = READ;
                n_d       = n_new;
                rd_cnt_d  = '0;
                out_cnt_d = '0;
                addr_d    = '0;
                rdy_w_d   = n_new > 13'(DEPTH) ? 2'b11 : 2'b01;
            end
            READ:     if (issue && rd_cnt_q == n_q - 13'd1) state_d = DRAIN;
            DRAIN: if (frame_done) begin
                state_d = WAIT_CLR;
                rdy_w_d = 2'b00;
            end
            WAIT_CLR: if (rdy == 2'b00) state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            rdy_w_q   <= '0;
            sinc_lo_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            rd_b_q    <= 1'b0;
            rd_cnt_q  <= '0;
            addr_q    <= '0;
            out_cnt_q <= '0;
            wp_q      <= 1'b0;
            rp_q      <= 1'b0;
            cnt_q     <= '0;
            mem_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            rdy_w_q   <= rdy_w_d;
            sinc_lo_q <= sinc_lo_d;
            rd_vld_q  <= rd_vld_d;
            rd_b_q    <= rd_b_d;
            rd_cnt_q  <= rd_cnt_d;
            addr_q    <= addr_d;
            out_cnt_q <= out_cnt_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
            mem_q     <= mem_d;
        end
    end
endmodule
